// File: rtl/adl_bus_register.sv
// adl_bus_register: registered ADL bus source mux.
// Selects one of NSRC byte sources by fixed priority (highest index wins) and
// registers it. With nothing selected, the held value is kept or, on INC,
// incremented with a one-cycle carry pulse on wrap. Multi-driver selection sets
// a sticky CONFLICT flag. All outputs are registered, so there is no
// combinational path from inputs to outputs.
module adl_bus_register #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      NSRC      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NSRC-1:0]       CNTL,
  input  logic [NSRC*WIDTH-1:0] IN,
  input  logic                  INC,
  input  logic                  CLR_CONFLICT,
  output logic [WIDTH-1:0]      OUT,
  output logic                  CARRY,
  output logic                  VALID,
  output logic                  CONFLICT
);

  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_valid;
  logic             r_conflict;

  logic             w_any;
  logic             w_multi;
  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] w_inc_val;
  logic             w_inc_carry;

  // Source decode: any request, more-than-one request, and priority-selected data.
  // CNTL & (CNTL-1) clears the lowest set bit; non-zero means two or more bits set.
  always_comb begin
    w_any      = |CNTL;
    w_multi    = |(CNTL & (CNTL - NSRC'(1)));
    w_sel_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (CNTL[i]) begin
        w_sel_data = IN[i*WIDTH +: WIDTH];
      end
    end
  end

  // Increment of the held value; the extra top bit is the carry out of the wrap.
  always_comb begin
    {w_inc_carry, w_inc_val} = {1'b0, r_out} + (WIDTH+1)'(1);
  end

  // Bus register: load beats increment beats hold; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_out   <= RESET_VAL;
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_any) begin
      r_out   <= w_sel_data;
      r_carry <= 1'b0;
      r_valid <= 1'b1;
    end else if (INC) begin
      r_out   <= w_inc_val;
      r_carry <= w_inc_carry;
      r_valid <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      r_valid <= 1'b0;
    end
  end

  // Sticky contention flag: a new conflict wins over a simultaneous clear.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_conflict <= 1'b0;
    end else if (w_multi) begin
      r_conflict <= 1'b1;
    end else if (CLR_CONFLICT) begin
      r_conflict <= 1'b0;
    end
  end

  assign OUT      = r_out;
  assign CARRY    = r_carry;
  assign VALID    = r_valid;
  assign CONFLICT = r_conflict;

endmodule

// File: tb/tb_adl_bus_register.sv
// Directed bench for adl_bus_register: a default 8x4 instance and a 16x6
// instance with non-zero reset value, checked with immediate assertions.
module tb_adl_bus_register;

  logic        clk;

  // default instance (WIDTH=8, NSRC=4)
  logic        rst_n_a;
  logic [3:0]  cntl_a;
  logic [31:0] in_a;
  logic        inc_a;
  logic        clr_a;
  logic [7:0]  out_a;
  logic        carry_a;
  logic        valid_a;
  logic        conflict_a;

  // wide instance (WIDTH=16, NSRC=6, RESET_VAL=0x1234)
  logic        rst_n_b;
  logic [5:0]  cntl_b;
  logic [95:0] in_b;
  logic        inc_b;
  logic        clr_b;
  logic [15:0] out_b;
  logic        carry_b;
  logic        valid_b;
  logic        conflict_b;

  int n_cmp;
  int n_err;

  adl_bus_register u_dut_a (
    .CLK          (clk),
    .RST_N        (rst_n_a),
    .CNTL         (cntl_a),
    .IN           (in_a),
    .INC          (inc_a),
    .CLR_CONFLICT (clr_a),
    .OUT          (out_a),
    .CARRY        (carry_a),
    .VALID        (valid_a),
    .CONFLICT     (conflict_a)
  );

  adl_bus_register #(
    .WIDTH     (16),
    .NSRC      (6),
    .RESET_VAL (16'h1234)
  ) u_dut_b (
    .CLK          (clk),
    .RST_N        (rst_n_b),
    .CNTL         (cntl_b),
    .IN           (in_b),
    .INC          (inc_b),
    .CLR_CONFLICT (clr_b),
    .OUT          (out_b),
    .CARRY        (carry_b),
    .VALID        (valid_b),
    .CONFLICT     (conflict_b)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // one rising edge, then settle away from the edge before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [7:0] e_out, input logic e_carry,
                         input logic e_valid, input logic e_conflict);
    chk({tag, ".out"},      32'(out_a),      32'(e_out));
    chk({tag, ".carry"},    32'(carry_a),    32'(e_carry));
    chk({tag, ".valid"},    32'(valid_a),    32'(e_valid));
    chk({tag, ".conflict"}, 32'(conflict_a), 32'(e_conflict));
  endtask

  task automatic check_b(input string tag, input logic [15:0] e_out, input logic e_carry,
                         input logic e_valid, input logic e_conflict);
    chk({tag, ".out"},      32'(out_b),      32'(e_out));
    chk({tag, ".carry"},    32'(carry_b),    32'(e_carry));
    chk({tag, ".valid"},    32'(valid_b),    32'(e_valid));
    chk({tag, ".conflict"}, 32'(conflict_b), 32'(e_conflict));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // reset with every select and INC asserted
    rst_n_a = 1'b0; cntl_a = 4'b1111; inc_a = 1'b1; clr_a = 1'b0;
    in_a    = {8'h44, 8'h33, 8'h22, 8'h11};
    rst_n_b = 1'b0; cntl_b = 6'b111111; inc_b = 1'b1; clr_b = 1'b0;
    in_b    = '0;
    tick();
    check_a("rst1", 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check_a("rst2", 8'h00, 1'b0, 1'b0, 1'b0);

    // priority load
    rst_n_a = 1'b1; cntl_a = 4'b0001; inc_a = 1'b0;
    tick();
    check_a("load0", 8'h11, 1'b0, 1'b1, 1'b0);
    cntl_a = 4'b0110;
    tick();
    check_a("load_conflict", 8'h33, 1'b0, 1'b1, 1'b1);
    cntl_a = 4'b1000;
    tick();
    check_a("load3", 8'h44, 1'b0, 1'b1, 1'b1);

    // hold vs increment across wrap
    in_a[7:0] = 8'hFE; cntl_a = 4'b0001;
    tick();
    check_a("load_fe", 8'hFE, 1'b0, 1'b1, 1'b1);
    cntl_a = 4'b0000; inc_a = 1'b0;
    tick();
    check_a("hold1", 8'hFE, 1'b0, 1'b0, 1'b1);
    tick();
    check_a("hold2", 8'hFE, 1'b0, 1'b0, 1'b1);
    tick();
    check_a("hold3", 8'hFE, 1'b0, 1'b0, 1'b1);
    inc_a = 1'b1;
    tick();
    check_a("inc_ff", 8'hFF, 1'b0, 1'b0, 1'b1);
    tick();
    check_a("inc_wrap", 8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    check_a("inc_01", 8'h01, 1'b0, 1'b0, 1'b1);

    // load beats increment
    inc_a = 1'b0; in_a[7:0] = 8'hFF; cntl_a = 4'b0001;
    tick();
    check_a("load_ff", 8'hFF, 1'b0, 1'b1, 1'b1);
    in_a[15:8] = 8'h80; cntl_a = 4'b0010; inc_a = 1'b1;
    tick();
    check_a("load_beats_inc", 8'h80, 1'b0, 1'b1, 1'b1);

    // conflict clear race
    cntl_a = 4'b0000; inc_a = 1'b0; clr_a = 1'b1;
    tick();
    check_a("clr_plain", 8'h80, 1'b0, 1'b0, 1'b0);
    cntl_a = 4'b0011; clr_a = 1'b1;
    tick();
    check_a("set_beats_clr", 8'h80, 1'b0, 1'b1, 1'b1);
    cntl_a = 4'b0001; clr_a = 1'b1;
    tick();
    check_a("clr_after", 8'hFF, 1'b0, 1'b1, 1'b0);
    clr_a = 1'b0;
    tick();
    check_a("stay_clear", 8'hFF, 1'b0, 1'b1, 1'b0);

    // reset overrides a conflicting load and clears the flag
    cntl_a = 4'b0011;
    tick();
    check_a("conflict_again", 8'h80, 1'b0, 1'b1, 1'b1);
    rst_n_a = 1'b0; inc_a = 1'b1;
    tick();
    check_a("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n_a = 1'b1; cntl_a = 4'b0000;
    tick();
    check_a("inc_after_rst", 8'h01, 1'b0, 1'b0, 1'b0);

    // wide instance
    check_b("b_rst", 16'h1234, 1'b0, 1'b0, 1'b0);
    rst_n_b = 1'b1; inc_b = 1'b0; cntl_b = 6'b100000;
    in_b[95:80] = 16'hABCD; in_b[15:0] = 16'hFFFF;
    tick();
    check_b("b_load5", 16'hABCD, 1'b0, 1'b1, 1'b0);
    cntl_b = 6'b000001;
    tick();
    check_b("b_load_ffff", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    cntl_b = 6'b000000; inc_b = 1'b1;
    tick();
    check_b("b_wrap", 16'h0000, 1'b1, 1'b0, 1'b0);
    tick();
    check_b("b_inc1", 16'h0001, 1'b0, 1'b0, 1'b0);
    inc_b = 1'b0;
    tick();
    check_b("b_hold", 16'h0001, 1'b0, 1'b0, 1'b0);
    cntl_b = 6'b100001;
    tick();
    check_b("b_conflict", 16'hABCD, 1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
